sin_lut_ctrl: RTL

- Controller for the sine look-up RAM in the mixer path. Drives both RAM ports.
- Write side: loads a RAM_DEPTH-entry sine table from a valid/ready stream.
- Read side: runs a phase accumulator (NCO) that addresses the table, then realigns the RAM's 2-cycle registered read data into a valid-qualified signed sample stream for the mixer.

---
 rtl/sin_lut_if.sv | 51 +++++
 rtl/sin_lut_ctrl.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/sin_lut_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sin_lut_if : table-load stream, sine-RAM ports and sample output bundle    |
// | Optional SIN_LUT_CHECKSUM_EN adds o_checksum.   Rev 1.0                     |
// +----------------------------------------------------------------------------+
interface sin_lut_if #(
    parameter int RAM_EXP   = 5,
    parameter int RAM_WIDTH = 8,
    parameter int PHASE_W   = 16
);
    logic                 i_load_start;
    logic [RAM_WIDTH-1:0] i_load_data;
    logic                 i_load_valid;
    logic                 o_load_ready;
    logic                 i_run;
    logic [PHASE_W-1:0]   i_fcw;
    logic [RAM_EXP-1:0]   o_addr_w;
    logic [RAM_WIDTH-1:0] o_data_ram;
    logic                 o_write_enb;
    logic [RAM_EXP-1:0]   o_addr_r;
    logic                 o_read_enb;
    logic [RAM_WIDTH-1:0] i_data_ram;
    logic [RAM_WIDTH-1:0] o_sample;
    logic                 o_sample_valid;
    logic                 o_table_ok;
    logic                 o_busy;
`ifdef SIN_LUT_CHECKSUM_EN
    logic [RAM_WIDTH+RAM_EXP-1:0] o_checksum;
`endif

    // Environment side: drives the stream, the run controls and the RAM read data.
    modport master (
        output i_load_start, i_load_data, i_load_valid, i_run, i_fcw, i_data_ram,
        input  o_load_ready, o_addr_w, o_data_ram, o_write_enb, o_addr_r,
               o_read_enb, o_sample, o_sample_valid, o_table_ok, o_busy
`ifdef SIN_LUT_CHECKSUM_EN
        , input o_checksum
`endif
    );

    // Controller side.
    modport slave (
        input  i_load_start, i_load_data, i_load_valid, i_run, i_fcw, i_data_ram,
        output o_load_ready, o_addr_w, o_data_ram, o_write_enb, o_addr_r,
               o_read_enb, o_sample, o_sample_valid, o_table_ok, o_busy
`ifdef SIN_LUT_CHECKSUM_EN
        , output o_checksum
`endif
    );
endinterface
`default_nettype wire

// File: rtl/sin_lut_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sin_lut_ctrl : sine-table loader plus NCO reader with RAM-latency realign  |
// | Optional macro SIN_LUT_CHECKSUM_EN adds a load checksum.   Rev 1.0          |
// +----------------------------------------------------------------------------+
module sin_lut_ctrl #(
    parameter int RAM_EXP   = 5,
    parameter int RAM_WIDTH = 8,
    parameter int PHASE_W   = 16
) (
    input  wire logic clk,
    input  wire logic i_rst,
    sin_lut_if.slave  bus
);
    localparam int RAM_DEPTH = 2 ** RAM_EXP;
    localparam logic [RAM_EXP-1:0] c_LAST = RAM_EXP'(RAM_DEPTH - 1);
    localparam logic [RAM_EXP-1:0] c_ONE  = RAM_EXP'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t               r_state;
    logic [PHASE_W-1:0]   r_phase;
    logic [RAM_EXP-1:0]   r_cnt;
    logic [1:0]           r_vld;
    logic                 r_load_ready;
    logic [RAM_EXP-1:0]   r_addr_w;
    logic [RAM_WIDTH-1:0] r_data_ram;
    logic                 r_write_enb;
    logic [RAM_EXP-1:0]   r_addr_r;
    logic                 r_read_enb;
    logic [RAM_WIDTH-1:0] r_sample;
    logic                 r_sample_valid;
    logic                 r_table_ok;
    logic                 r_busy;

    logic                 w_accept;
    logic [PHASE_W-1:0]   w_phase_nxt;

    assign w_accept    = (r_state == S_LOAD) && bus.i_load_valid && r_load_ready;
    assign w_phase_nxt = r_phase + bus.i_fcw;

`ifdef SIN_LUT_CHECKSUM_EN
    logic [RAM_WIDTH+RAM_EXP-1:0] r_checksum;

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_checksum <= '0;
        end else if ((r_state == S_IDLE) && bus.i_load_start) begin
            r_checksum <= '0;
        end else if (w_accept) begin
            r_checksum <= r_checksum + {{RAM_EXP{1'b0}}, bus.i_load_data};
        end
    end

    assign bus.o_checksum = r_checksum;
`endif

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_state        <= S_IDLE;
            r_phase        <= '0;
            r_cnt          <= '0;
            r_vld          <= '0;
            r_load_ready   <= 1'b0;
            r_addr_w       <= '0;
            r_data_ram     <= '0;
            r_write_enb    <= 1'b0;
            r_addr_r       <= '0;
            r_read_enb     <= 1'b0;
            r_sample       <= '0;
            r_sample_valid <= 1'b0;
            r_table_ok     <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_write_enb <= 1'b0;

            // Two stages cover the RAM latency; the third edge captures the data.
            r_vld <= {r_vld[0], r_read_enb};
            if (r_vld[1]) begin
                r_sample       <= bus.i_data_ram;
                r_sample_valid <= 1'b1;
            end else begin
                r_sample_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (bus.i_load_start) begin
                        r_state      <= S_LOAD;
                        r_cnt        <= '0;
                        r_phase      <= '0;
                        r_table_ok   <= 1'b0;
                        r_busy       <= 1'b1;
                        r_load_ready <= 1'b1;
                    end else if (bus.i_run && r_table_ok) begin
                        r_state    <= S_RUN;
                        r_read_enb <= 1'b1;
                        r_addr_r   <= r_phase[PHASE_W-1 -: RAM_EXP];
                        r_phase    <= w_phase_nxt;
                    end
                end
                S_LOAD: begin
                    if (w_accept) begin
                        r_write_enb <= 1'b1;
                        r_addr_w    <= r_cnt;
                        r_data_ram  <= bus.i_load_data;
                        r_cnt       <= r_cnt + c_ONE;
                        if (r_cnt == c_LAST) begin
                            r_state      <= S_IDLE;
                            r_busy       <= 1'b0;
                            r_load_ready <= 1'b0;
                            r_table_ok   <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (bus.i_run) begin
                        r_read_enb <= 1'b1;
                        r_addr_r   <= r_phase[PHASE_W-1 -: RAM_EXP];
                        r_phase    <= w_phase_nxt;
                    end else begin
                        r_state    <= S_IDLE;
                        r_read_enb <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.o_load_ready   = r_load_ready;
    assign bus.o_addr_w       = r_addr_w;
    assign bus.o_data_ram     = r_data_ram;
    assign bus.o_write_enb    = r_write_enb;
    assign bus.o_addr_r       = r_addr_r;
    assign bus.o_read_enb     = r_read_enb;
    assign bus.o_sample       = r_sample;
    assign bus.o_sample_valid = r_sample_valid;
    assign bus.o_table_ok     = r_table_ok;
    assign bus.o_busy         = r_busy;
endmodule
`default_nettype wire
